// File: rtl/baccarat_sequencer_if.sv
// Round-sequencer bus: step/score inputs from the datapath, load strobes and lights back.
// Latency: carries no state; every signal is a plain wire bundle.
// Backpressure: none; 'step' is the only pacing signal, the sequencer never stalls its source.
interface baccarat_sequencer_if;
  logic       step;
  logic       new_round;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       clr_hand;
  logic       player_win_light;
  logic       dealer_win_light;

  // Card source / board side: drives pacing and hand totals, observes strobes and lights.
  modport master (
    output step, new_round, pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  clr_hand, player_win_light, dealer_win_light
  );

  // Sequencer side.
  modport slave (
    input  step, new_round, pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output clr_hand, player_win_light, dealer_win_light
  );
endinterface

// File: rtl/baccarat_sequencer.sv
// Baccarat round control FSM: deals four cards, applies third-card rules, lights the winner.
// Latency: one state per stepped edge; strobes are combinational, lights register one edge after entering RESULT.
// Backpressure: the FSM waits on 'step' in every state except the light-latch in RESULT; nothing is driven while waiting.
// Optional: define BACCARAT_TALLY_EN to add saturating player/dealer win tallies.
module baccarat_sequencer #(
  parameter int NONE_STATE_W = 4
) (
  input  logic                    slow_clock,
  input  logic                    reset,
  baccarat_sequencer_if.slave     bus,
  output logic [NONE_STATE_W-1:0] state_dbg
`ifdef BACCARAT_TALLY_EN
  ,
  output logic [3:0]              player_tally,
  output logic [3:0]              dealer_tally
`endif
);

  typedef enum logic [3:0] {
    P1     = 4'd0,
    D1     = 4'd1,
    P2     = 4'd2,
    D2     = 4'd3,
    EVAL   = 4'd4,
    P3     = 4'd5,
    EVALD  = 4'd6,
    D3     = 4'd7,
    RESULT = 4'd8
  } state_t;

  state_t     state;
  logic       lights_pending;  // first RESULT cycle: totals are final, latch the lights next edge
  logic       player_light;
  logic       dealer_light;

  logic       adv;             // a step that is allowed to act this cycle
  logic [3:0] third_val;       // baccarat value of the player's third card
  logic       natural;
  logic       dealer_draws;

  assign adv = bus.step && !reset;

  // Face cards and tens count zero; illegal codes (0, 14, 15) fall out as zero too.
  assign third_val = (bus.pcard3 <= 4'd9) ? bus.pcard3 : 4'd0;

  assign natural = (bus.pscore >= 4'd8) || (bus.dscore >= 4'd8);

  // Dealer tableau once the player has taken a third card.
  always_comb begin
    dealer_draws = 1'b0;
    case (bus.dscore)
      4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
      4'd3:             dealer_draws = (third_val != 4'd8);
      4'd4:             dealer_draws = (third_val >= 4'd2) && (third_val <= 4'd7);
      4'd5:             dealer_draws = (third_val >= 4'd4) && (third_val <= 4'd7);
      4'd6:             dealer_draws = (third_val == 4'd6) || (third_val == 4'd7);
      default:          dealer_draws = 1'b0;
    endcase
  end

  // Load strobes fire in the cycle the FSM leaves the matching state, so the
  // hand register and the FSM move on the same edge.
  assign bus.load_pcard1 = adv && (state == P1);
  assign bus.load_dcard1 = adv && (state == D1);
  assign bus.load_pcard2 = adv && (state == P2);
  assign bus.load_dcard2 = adv && (state == D2);
  assign bus.load_pcard3 = adv && (state == P3);
  assign bus.load_dcard3 = adv && (state == D3);
  assign bus.clr_hand    = adv && bus.new_round && (state == RESULT);

  assign bus.player_win_light = player_light;
  assign bus.dealer_win_light = dealer_light;

  assign state_dbg = NONE_STATE_W'(state);

  // Round sequencing, light latch and (optionally) win tallies.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state          <= P1;
      lights_pending <= 1'b0;
      player_light   <= 1'b0;
      dealer_light   <= 1'b0;
`ifdef BACCARAT_TALLY_EN
      player_tally   <= 4'd0;
      dealer_tally   <= 4'd0;
`endif
    end else begin
      case (state)
        P1: if (bus.step) state <= D1;
        D1: if (bus.step) state <= P2;
        P2: if (bus.step) state <= D2;
        D2: if (bus.step) state <= EVAL;

        EVAL: begin
          if (bus.step) begin
            if (natural) begin
              state          <= RESULT;
              lights_pending <= 1'b1;
            end else if (bus.pscore <= 4'd5) begin
              state <= P3;
            end else if (bus.dscore <= 4'd5) begin
              state <= D3;
            end else begin
              state          <= RESULT;
              lights_pending <= 1'b1;
            end
          end
        end

        P3: if (bus.step) state <= EVALD;

        EVALD: begin
          if (bus.step) begin
            if (dealer_draws) begin
              state <= D3;
            end else begin
              state          <= RESULT;
              lights_pending <= 1'b1;
            end
          end
        end

        // The dealer's third card lands on this edge; its total is only
        // visible during the first RESULT cycle, hence the deferred latch.
        D3: begin
          if (bus.step) begin
            state          <= RESULT;
            lights_pending <= 1'b1;
          end
        end

        RESULT: begin
          if (bus.step && bus.new_round) begin
            state          <= P1;
            lights_pending <= 1'b0;
            player_light   <= 1'b0;
            dealer_light   <= 1'b0;
          end else if (lights_pending) begin
            lights_pending <= 1'b0;
            player_light   <= (bus.pscore >= bus.dscore);
            dealer_light   <= (bus.dscore >= bus.pscore);
`ifdef BACCARAT_TALLY_EN
            if ((bus.pscore > bus.dscore) && (player_tally != 4'hF))
              player_tally <= player_tally + 4'd1;
            if ((bus.dscore > bus.pscore) && (dealer_tally != 4'hF))
              dealer_tally <= dealer_tally + 4'd1;
`endif
          end
        end

        default: begin
          state          <= P1;
          lights_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_baccarat_sequencer.sv
// Self-checking bench for baccarat_sequencer: directed rounds plus a per-cycle reference model.
// Latency: inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// Backpressure: the bench paces the DUT purely through step/new_round.
module tb_baccarat_sequencer;

  logic       slow_clock = 1'b0;
  logic       reset;
  logic [3:0] state_dbg;
`ifdef BACCARAT_TALLY_EN
  logic [3:0] player_tally;
  logic [3:0] dealer_tally;
`endif

  baccarat_sequencer_if bus ();

  baccarat_sequencer #(.NONE_STATE_W(4)) dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .bus        (bus),
    .state_dbg  (state_dbg)
`ifdef BACCARAT_TALLY_EN
    ,
    .player_tally (player_tally),
    .dealer_tally (dealer_tally)
`endif
  );

  initial forever #5 slow_clock = ~slow_clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Position in the round uses the published state numbering; the dealer
  // tableau is a table of "draws on third-card value" masks per dealer total.
  logic [9:0] draw_mask [0:7];
  int  m_pos   = 0;
  bit  m_first = 0;
  bit  m_pl    = 0;
  bit  m_dl    = 0;
  int  m_pt    = 0;
  int  m_dt    = 0;
  bit  m_valid = 0;

  initial begin
    draw_mask[0] = 10'h3FF;
    draw_mask[1] = 10'h3FF;
    draw_mask[2] = 10'h3FF;
    draw_mask[3] = 10'h2FF;  // everything but 8
    draw_mask[4] = 10'h0FC;  // 2..7
    draw_mask[5] = 10'h0F0;  // 4..7
    draw_mask[6] = 10'h0C0;  // 6,7
    draw_mask[7] = 10'h000;
  end

  always @(posedge slow_clock) begin
    int p, d, v;
    p = int'(bus.pscore);
    d = int'(bus.dscore);
    v = (bus.pcard3 > 4'd9) ? 0 : int'(bus.pcard3);
    if (reset) begin
      m_pos = 0; m_first = 0; m_pl = 0; m_dl = 0; m_pt = 0; m_dt = 0; m_valid = 1;
    end else if (m_valid) begin
      if (m_pos <= 3) begin
        if (bus.step) m_pos = m_pos + 1;
      end else if (m_pos == 4) begin
        if (bus.step) begin
          if (p >= 8 || d >= 8) begin m_pos = 8; m_first = 1; end
          else if (p <= 5) m_pos = 5;
          else if (d <= 5) m_pos = 7;
          else begin m_pos = 8; m_first = 1; end
        end
      end else if (m_pos == 5) begin
        if (bus.step) m_pos = 6;
      end else if (m_pos == 6) begin
        if (bus.step) begin
          if (d <= 7 && draw_mask[d][v]) m_pos = 7;
          else begin m_pos = 8; m_first = 1; end
        end
      end else if (m_pos == 7) begin
        if (bus.step) begin m_pos = 8; m_first = 1; end
      end else begin
        if (bus.step && bus.new_round) begin
          m_pos = 0; m_first = 0; m_pl = 0; m_dl = 0;
        end else if (m_first) begin
          m_first = 0;
          m_pl = (p >= d);
          m_dl = (d >= p);
          if (p > d && m_pt < 15) m_pt++;
          if (d > p && m_dt < 15) m_dt++;
        end
      end
    end
  end

  // One compare process: every cycle after the first reset edge.
  always @(negedge slow_clock) begin
    logic [8:0] exp_o, got_o;
    bit go;
    if (m_valid) begin
      go = !reset && bus.step;
      exp_o = {go && m_pos == 0, go && m_pos == 1, go && m_pos == 2, go && m_pos == 3,
               go && m_pos == 5, go && m_pos == 7, go && bus.new_round && m_pos == 8,
               m_pl, m_dl};
      got_o = {bus.load_pcard1, bus.load_dcard1, bus.load_pcard2, bus.load_dcard2,
               bus.load_pcard3, bus.load_dcard3, bus.clr_hand,
               bus.player_win_light, bus.dealer_win_light};
      chk("cyc_outputs", int'(got_o), int'(exp_o));
      chk("cyc_state", int'(state_dbg), m_pos);
`ifdef BACCARAT_TALLY_EN
      chk("cyc_ptally", int'(player_tally), m_pt);
      chk("cyc_dtally", int'(dealer_tally), m_dt);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic s, input logic nr);
    bus.step = s;
    bus.new_round = nr;
    #1;
  endtask

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  // Four dealing steps with an idle cycle after the first; strobe order pinned literally.
  task automatic deal4(input logic [3:0] p, input logic [3:0] d);
    logic [3:0] got;
    bus.pscore = p;
    bus.dscore = d;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0);
      got = {bus.load_pcard1, bus.load_dcard1, bus.load_pcard2, bus.load_dcard2};
      chk("deal_strobe", int'(got), 8 >> i);
      tick();
      chk("deal_state", int'(state_dbg), i + 1);
      if (i == 0) begin
        drive(1'b0, 1'b0);
        got = {bus.load_pcard1, bus.load_dcard1, bus.load_pcard2, bus.load_dcard2};
        chk("idle_strobe", int'(got), 0);
        tick();
        chk("idle_state", int'(state_dbg), 1);
      end
    end
  endtask

  // From the first RESULT cycle: check lights, hold behaviour and the new-round exit.
  task automatic finish_result(input logic ep, input logic ed);
    drive(1'b0, 1'b0);
    chk("lights_pre", int'({bus.player_win_light, bus.dealer_win_light}), 0);
    tick();
    chk("lights", int'({bus.player_win_light, bus.dealer_win_light}), int'({ep, ed}));
    drive(1'b1, 1'b0);
    tick();
    chk("result_hold", int'(state_dbg), 8);
    chk("lights_hold", int'({bus.player_win_light, bus.dealer_win_light}), int'({ep, ed}));
    drive(1'b1, 1'b1);
    chk("clr_hand", int'(bus.clr_hand), 1);
    tick();
    chk("exit_state", int'(state_dbg), 0);
    chk("exit_lights", int'({bus.player_win_light, bus.dealer_win_light}), 0);
    drive(1'b0, 1'b0);
  endtask

  task automatic step_to(input int exp_state);
    drive(1'b1, 1'b0);
    tick();
    chk("step_state", int'(state_dbg), exp_state);
  endtask

  // EVALD vectors: dealer total, pcard3 code, next state, expected lights (player total fixed at 4).
  int tv [12][5] = '{
    '{3, 8, 8, 1, 0}, '{3, 13, 7, 1, 0}, '{3, 0, 7, 1, 0}, '{4, 2, 7, 1, 1},
    '{4, 1, 8, 1, 1}, '{5, 4, 7, 0, 1}, '{5, 8, 8, 0, 1}, '{6, 6, 7, 0, 1},
    '{6, 15, 8, 0, 1}, '{2, 8, 7, 1, 0}, '{7, 7, 8, 0, 1}, '{0, 9, 7, 1, 0}
  };

  initial begin
    reset = 1'b1;
    bus.step = 1'b1;
    bus.new_round = 1'b0;
    bus.pscore = 4'd0;
    bus.dscore = 4'd0;
    bus.pcard3 = 4'd1;
    tick();
    tick();
    // Reset beats step: no strobe while reset is high.
    chk("rst_strobe", int'(bus.load_pcard1), 0);
    chk("rst_state", int'(state_dbg), 0);
    chk("rst_lights", int'({bus.player_win_light, bus.dealer_win_light}), 0);
    reset = 1'b0;
    drive(1'b0, 1'b0);
    tick();
    chk("rst_hold", int'(state_dbg), 0);

    // Natural: player 9 vs dealer 3.
    deal4(4'd9, 4'd3);
    step_to(8);
    finish_result(1'b1, 1'b0);

    // Player stands on 7, dealer 4 draws; final dealer total 9.
    deal4(4'd7, 4'd4);
    step_to(7);
    drive(1'b1, 1'b0);
    chk("d3_strobe", int'({bus.load_pcard3, bus.load_dcard3}), 1);
    tick();
    chk("d3_state", int'(state_dbg), 8);
    bus.dscore = 4'd9;
    finish_result(1'b0, 1'b1);

    // Player 3 draws a 7 (total 0); dealer 6 draws on 7, ends at 2.
    deal4(4'd3, 4'd6);
    step_to(5);
    drive(1'b1, 1'b0);
    chk("p3_strobe", int'({bus.load_pcard3, bus.load_dcard3}), 2);
    tick();
    chk("p3_state", int'(state_dbg), 6);
    bus.pcard3 = 4'd7;
    bus.pscore = 4'd0;
    step_to(7);
    step_to(8);
    bus.dscore = 4'd2;
    finish_result(1'b0, 1'b1);

    // Same, but a queen (value 0): dealer 6 stands.
    deal4(4'd3, 4'd6);
    step_to(5);
    step_to(6);
    bus.pcard3 = 4'd12;
    bus.pscore = 4'd3;
    step_to(8);
    finish_result(1'b0, 1'b1);

    // Tie at 5-5: player 2 draws a 3, dealer 5 stands on 3.
    deal4(4'd2, 4'd5);
    step_to(5);
    step_to(6);
    bus.pcard3 = 4'd3;
    bus.pscore = 4'd5;
    step_to(8);
    finish_result(1'b1, 1'b1);

    // Both stand: player 6, dealer 7.
    deal4(4'd6, 4'd7);
    step_to(8);
    finish_result(1'b0, 1'b1);

    // Dealer tableau vectors.
    for (int i = 0; i < 12; i++) begin
      deal4(4'd4, 4'(tv[i][0]));
      step_to(5);
      step_to(6);
      bus.pcard3 = 4'(tv[i][1]);
      step_to(tv[i][2]);
      if (tv[i][2] == 7) step_to(8);
      finish_result(1'(tv[i][3]), 1'(tv[i][4]));
    end

    // Reset while in P3 abandons the round without a strobe.
    deal4(4'd1, 4'd7);
    step_to(5);
    reset = 1'b1;
    drive(1'b1, 1'b0);
    chk("rst_p3_strobe", int'(bus.load_pcard3), 0);
    tick();
    chk("rst_p3_state", int'(state_dbg), 0);
    chk("rst_p3_lights", int'({bus.player_win_light, bus.dealer_win_light}), 0);
    reset = 1'b0;
    drive(1'b0, 1'b0);
    tick();

`ifdef BACCARAT_TALLY_EN
    chk("tally_after_rst", int'({player_tally, dealer_tally}), 0);
    for (int r = 0; r < 16; r++) begin
      deal4(4'd9, 4'd0);
      step_to(8);
      finish_result(1'b1, 1'b0);
    end
    chk("ptally_sat", int'(player_tally), 15);
    chk("dtally_zero", int'(dealer_tally), 0);
    deal4(4'd8, 4'd8);
    step_to(8);
    finish_result(1'b1, 1'b1);
    chk("ptally_tie", int'(player_tally), 15);
    chk("dtally_tie", int'(dealer_tally), 0);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog: the directed run is a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
